// File: rtl/lut_pkg.sv
// Shared definitions for the LUT runtime loader.
//   lut_state_e      : loader FSM states
//   LUT_DEPTH        : words per coefficient table
//   LUT_ADDR_WIDTH   : table address width
//   LUT_DATA_WIDTH   : table word width
//   LUT_READ_LATENCY : table read latency (registered address + registered q)
package lut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    CHECK  = 2'd3
  } lut_state_e;

  localparam int LUT_DEPTH        = 3072;
  localparam int LUT_ADDR_WIDTH   = 12;
  localparam int LUT_DATA_WIDTH   = 32;
  localparam int LUT_READ_LATENCY = 2;

endpackage

// File: rtl/lut_loader_if.sv
// Bundle between the loader, the host/DMA word stream and one table port.
//   in_data/in_valid/in_ready : host word stream (valid/ready)
//   mem_address/mem_data      : table address and write data
//   mem_wren/mem_rden         : table write and read enables
//   mem_q                     : table read data
// Modports: master = loader side, slave = host stream + table side.
interface lut_loader_if #(
  parameter int ADDR_WIDTH = lut_pkg::LUT_ADDR_WIDTH,
  parameter int DATA_WIDTH = lut_pkg::LUT_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_wren;
  logic                  mem_rden;
  logic [DATA_WIDTH-1:0] mem_q;

  modport master (
    input  in_data, in_valid, mem_q,
    output in_ready, mem_address, mem_data, mem_wren, mem_rden
  );

  modport slave (
    output in_data, in_valid, mem_q,
    input  in_ready, mem_address, mem_data, mem_wren, mem_rden
  );

endinterface

// File: rtl/lut_readback_pipe.sv
// Readback tracker: a READ_LATENCY-deep valid shift register follows each
// issued read to the cycle its q is valid, and accumulates q into rsum.
//   clock, rst_n : clock, synchronous active-low reset
//   clear        : restart tracking (new load)
//   rden         : read issued to the table this cycle
//   q            : table read data
//   rsum         : running sum of returned words, mod 2^DATA_WIDTH
//   last_return  : the final (DEPTH-th) return is valid this cycle
module lut_readback_pipe
  import lut_pkg::*;
#(
  parameter int DEPTH        = LUT_DEPTH,
  parameter int DATA_WIDTH   = LUT_DATA_WIDTH,
  parameter int READ_LATENCY = LUT_READ_LATENCY
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  rden,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] rsum,
  output logic                  last_return
);

  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DEPTH - 1);

  logic [READ_LATENCY-1:0] vld;
  logic [CNT_WIDTH-1:0]    ret_cnt;

  always_ff @(posedge clock) begin
    if (!rst_n || clear) begin
      vld     <= '0;
      rsum    <= '0;
      ret_cnt <= '0;
    end else begin
      vld[0] <= rden;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end
      if (vld[READ_LATENCY-1]) begin
        rsum    <= rsum + q;
        ret_cnt <= ret_cnt + 1'b1;
      end
    end
  end

  assign last_return = vld[READ_LATENCY-1] && (ret_cnt == LAST_IDX);

endmodule

// File: rtl/lut_loader.sv
// Runtime loader for one coefficient LUT: writes a DEPTH-word stream into
// the table, reads it all back and compares additive checksums.
//   clock, rst_n : clock, synchronous active-low reset
//   start        : one-cycle pulse, begins a load when idle
//   bus          : stream + table port bundle (master side)
//   busy         : table owned by the loader (LOAD/VERIFY)
//   done         : one-cycle pulse at end of verify
//   error        : readback checksum mismatch, held until next start
//   checksum     : sum of written words mod 2^DATA_WIDTH
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting stream words, one table write per accepted beat
// VERIFY | issuing DEPTH reads and summing returns until the pipe drains
// CHECK  | one cycle: done, checksum and error presented
module lut_loader
  import lut_pkg::*;
#(
  parameter int DEPTH        = LUT_DEPTH,
  parameter int ADDR_WIDTH   = LUT_ADDR_WIDTH,
  parameter int DATA_WIDTH   = LUT_DATA_WIDTH,
  parameter int READ_LATENCY = LUT_READ_LATENCY
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  lut_loader_if.master          bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_DEPTH = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(DEPTH - 1);

  lut_state_e state, state_nxt;

  logic                  in_ready;
  logic                  accept;
  logic                  load_start;
  logic [CNT_WIDTH-1:0]  wr_cnt;
  logic [CNT_WIDTH-1:0]  rd_cnt;
  logic [DATA_WIDTH-1:0] wsum;
  logic [DATA_WIDTH-1:0] rsum;
  logic                  last_return;
  logic                  error_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic                  mem_wren_q;
  logic                  mem_rden_q;

  always_ff @(posedge clock) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    load_start = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = (wr_cnt < CNT_DEPTH);
        accept   = in_ready && bus.in_valid;
        if (accept && (wr_cnt == LAST_IDX)) state_nxt = VERIFY;
      end
      VERIFY: begin
        busy = 1'b1;
        if (last_return) state_nxt = CHECK;
      end
      CHECK: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Table port is fully registered. Reads start only once the FSM is in
  // VERIFY, i.e. the cycle after the last write, so wren/rden never overlap.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      wsum          <= '0;
      error_q       <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      mem_rden_q    <= 1'b0;
    end else begin
      mem_wren_q <= 1'b0;
      mem_rden_q <= 1'b0;
      if (load_start) begin
        wr_cnt  <= '0;
        rd_cnt  <= '0;
        wsum    <= '0;
        error_q <= 1'b0;
      end
      if (accept) begin
        mem_address_q <= ADDR_WIDTH'(wr_cnt);
        mem_data_q    <= bus.in_data;
        mem_wren_q    <= 1'b1;
        wr_cnt        <= wr_cnt + 1'b1;
        wsum          <= wsum + bus.in_data;
      end
      if ((state == VERIFY) && (rd_cnt < CNT_DEPTH)) begin
        mem_address_q <= ADDR_WIDTH'(rd_cnt);
        mem_rden_q    <= 1'b1;
        rd_cnt        <= rd_cnt + 1'b1;
      end
      if (state == CHECK) error_q <= (rsum != wsum);
    end
  end

  lut_readback_pipe #(
    .DEPTH        (DEPTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .READ_LATENCY (READ_LATENCY)
  ) u_readback (
    .clock       (clock),
    .rst_n       (rst_n),
    .clear       (load_start),
    .rden        (mem_rden_q),
    .q           (bus.mem_q),
    .rsum        (rsum),
    .last_return (last_return)
  );

  // error must be valid in the done cycle itself, so CHECK shows the live
  // compare; the registered copy holds it afterwards.
  assign error           = (state == CHECK) ? (rsum != wsum) : error_q;
  assign checksum        = wsum;
  assign bus.in_ready    = in_ready;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_wren    = mem_wren_q;
  assign bus.mem_rden    = mem_rden_q;

endmodule

// File: tb/tb_lut_loader.sv
// Directed bench for lut_loader: DEPTH=8 and DEPTH=1 instances, each with a
// behavioural 2-cycle-latency table model.
module tb_lut_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start8, busy8, done8, error8;
  logic [31:0] checksum8;
  logic        start1, busy1, done1, error1;
  logic [31:0] checksum1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] words8 [0:7];
  bit          corrupt = 1'b0;
  int wr_seen8, rd_seen8, done_cnt8;
  int wr_seen1, rd_seen1, done_cnt1;

  lut_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b8 ();
  lut_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) b1 ();

  lut_loader #(.DEPTH(8), .ADDR_WIDTH(12), .DATA_WIDTH(32), .READ_LATENCY(2)) dut8 (
    .clock(clk), .rst_n(rst_n), .start(start8), .bus(b8),
    .busy(busy8), .done(done8), .error(error8), .checksum(checksum8)
  );

  lut_loader #(.DEPTH(1), .ADDR_WIDTH(12), .DATA_WIDTH(32), .READ_LATENCY(2)) dut1 (
    .clock(clk), .rst_n(rst_n), .start(start1), .bus(b1),
    .busy(busy1), .done(done1), .error(error1), .checksum(checksum1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Table models: registered address then registered q (latency 2).
  logic [31:0] tbl8 [0:4095];
  logic [31:0] tbl1 [0:4095];
  logic [11:0] raddr8, raddr1;

  always @(posedge clk) begin
    if (b8.mem_wren) tbl8[b8.mem_address] <= b8.mem_data;
    raddr8   <= b8.mem_address;
    b8.mem_q <= tbl8[raddr8] + {31'd0, corrupt && (raddr8 == 12'd5)};
    if (b1.mem_wren) tbl1[b1.mem_address] <= b1.mem_data;
    raddr1   <= b1.mem_address;
    b1.mem_q <= tbl1[raddr1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (b8.mem_wren) begin
        check("wr_addr8", 32'(b8.mem_address), 32'(wr_seen8));
        check("wr_data8", b8.mem_data, words8[wr_seen8 % 8]);
        check("overlap8", 32'(b8.mem_rden), 32'd0);
        wr_seen8++;
      end
      if (b8.mem_rden) begin
        check("rd_addr8", 32'(b8.mem_address), 32'(rd_seen8));
        rd_seen8++;
      end
      if (done8) done_cnt8++;
      if (b1.mem_wren) begin
        check("wr_addr1", 32'(b1.mem_address), 32'd0);
        check("wr_data1", b1.mem_data, 32'hA5A5A5A5);
        check("overlap1", 32'(b1.mem_rden), 32'd0);
        wr_seen1++;
      end
      if (b1.mem_rden) begin
        check("rd_addr1", 32'(b1.mem_address), 32'd0);
        rd_seen1++;
      end
      if (done1) done_cnt1++;
    end
  end

  task automatic check_zero8(input string p);
    check({p, "_in_ready"}, 32'(b8.in_ready),    32'd0);
    check({p, "_address"},  32'(b8.mem_address), 32'd0);
    check({p, "_data"},     b8.mem_data,         32'd0);
    check({p, "_wren"},     32'(b8.mem_wren),    32'd0);
    check({p, "_rden"},     32'(b8.mem_rden),    32'd0);
    check({p, "_busy"},     32'(busy8),          32'd0);
    check({p, "_done"},     32'(done8),          32'd0);
    check({p, "_error"},    32'(error8),         32'd0);
    check({p, "_checksum"}, checksum8,           32'd0);
  endtask

  task automatic set_words(input bit all_ones);
    for (int i = 0; i < 8; i++) words8[i] = all_ones ? 32'hFFFFFFFF : 32'(i + 1);
  endtask

  task automatic run8(input bit toggle, input bit start_in_verify,
                      output logic [31:0] cs, output logic er);
    int idx, last_acc;
    bit got_done;
    wr_seen8 = 0; rd_seen8 = 0; done_cnt8 = 0;
    cs = '0; er = 1'b0; last_acc = 0;
    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    check("busy_after_start8", 32'(busy8), 32'd1);
    check("error_clr_on_start8", 32'(error8), 32'd0);
    idx = 0;
    for (int c = 0; c < 200 && idx < 8; c++) begin
      b8.in_valid = toggle ? (c % 3 == 0) : 1'b1;
      b8.in_data  = words8[idx];
      @(negedge clk);
      if (b8.in_valid && b8.in_ready) begin
        idx++;
        last_acc = cyc;
      end
      @(posedge clk); #1;
    end
    b8.in_valid = 1'b0;
    check("beats_accepted8", 32'(idx), 32'd8);
    got_done = 1'b0;
    for (int t = 0; t < 100 && !got_done; t++) begin
      @(negedge clk);
      if (done8) begin
        got_done = 1'b1;
        cs = checksum8;
        er = error8;
        check("busy_at_done8", 32'(busy8), 32'd0);
        check("latency8", 32'(cyc - last_acc), 32'd12);
      end
      if (start_in_verify && t == 2) start8 = 1'b1;
      if (start_in_verify && t == 3) start8 = 1'b0;
    end
    start8 = 1'b0;
    check("done_seen8", 32'(got_done), 32'd1);
    repeat (20) @(negedge clk);
    check("done_count8", 32'(done_cnt8), 32'd1);
    check("write_count8", 32'(wr_seen8), 32'd8);
    check("read_count8", 32'(rd_seen8), 32'd8);
    check("idle_ready8", 32'(b8.in_ready), 32'd0);
    check("idle_busy8", 32'(busy8), 32'd0);
  endtask

  initial begin
    logic [31:0] cs;
    logic        er;
    int          idx, last_acc;
    bit          got_done, acc;

    rst_n = 1'b0;
    start8 = 1'b0; start1 = 1'b0;
    b8.in_valid = 1'b0; b8.in_data = '0;
    b1.in_valid = 1'b0; b1.in_data = '0;
    wr_seen8 = 0; rd_seen8 = 0; done_cnt8 = 0;
    wr_seen1 = 0; rd_seen1 = 0; done_cnt1 = 0;
    set_words(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero8("reset");
    rst_n = 1'b1;

    // 1..8, valid held high
    run8(1'b0, 1'b0, cs, er);
    check("checksum_basic", cs, 32'd36);
    check("error_basic", 32'(er), 32'd0);

    // 1..8, valid toggling 1,0,0
    run8(1'b1, 1'b0, cs, er);
    check("checksum_toggle", cs, 32'd36);
    check("error_toggle", 32'(er), 32'd0);

    // readback of address 5 corrupted
    corrupt = 1'b1;
    run8(1'b0, 1'b0, cs, er);
    check("checksum_corrupt", cs, 32'd36);
    check("error_corrupt", 32'(er), 32'd1);
    check("error_held", 32'(error8), 32'd1);
    corrupt = 1'b0;
    run8(1'b0, 1'b0, cs, er);
    check("error_after_clean", 32'(er), 32'd0);

    // all-ones words wrap the sum
    set_words(1'b1);
    run8(1'b0, 1'b0, cs, er);
    check("checksum_wrap", cs, 32'hFFFFFFF8);
    check("error_wrap", 32'(er), 32'd0);

    // reset after the 4th write
    set_words(1'b0);
    wr_seen8 = 0; rd_seen8 = 0;
    @(posedge clk); #1 start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    b8.in_valid = 1'b1;
    idx = 0;
    for (int c = 0; c < 50; c++) begin
      b8.in_data = words8[idx % 8];
      @(negedge clk); #1;
      if (wr_seen8 >= 4) break;
      if (b8.in_valid && b8.in_ready) idx++;
      @(posedge clk); #1;
    end
    check("reset_reached_write4", 32'(wr_seen8), 32'd4);
    rst_n = 1'b0;
    b8.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero8("midreset");
    rst_n = 1'b1;
    run8(1'b0, 1'b0, cs, er);
    check("checksum_restart", cs, 32'd36);
    check("error_restart", 32'(er), 32'd0);

    // start pulsed during VERIFY is ignored
    run8(1'b0, 1'b1, cs, er);
    check("checksum_startverify", cs, 32'd36);

    // DEPTH=1 instance
    wr_seen1 = 0; rd_seen1 = 0; done_cnt1 = 0;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    b1.in_valid = 1'b1;
    b1.in_data  = 32'hA5A5A5A5;
    acc = 1'b0; last_acc = 0;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge clk);
      if (b1.in_valid && b1.in_ready) begin
        acc = 1'b1;
        last_acc = cyc;
      end
      @(posedge clk); #1;
    end
    b1.in_valid = 1'b0;
    check("accepted1", 32'(acc), 32'd1);
    got_done = 1'b0;
    for (int t = 0; t < 50 && !got_done; t++) begin
      @(negedge clk);
      if (done1) begin
        got_done = 1'b1;
        check("latency1", 32'(cyc - last_acc), 32'd5);
        check("checksum1", checksum1, 32'hA5A5A5A5);
        check("error1", 32'(error1), 32'd0);
        check("busy_at_done1", 32'(busy1), 32'd0);
      end
    end
    check("done_seen1", 32'(got_done), 32'd1);
    repeat (10) @(negedge clk);
    check("write_count1", 32'(wr_seen1), 32'd1);
    check("read_count1", 32'(rd_seen1), 32'd1);
    check("done_count1", 32'(done_cnt1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_loader.md
Name: lut_loader

Overview:
- Runtime loader for the single-port 32-bit interpolation coefficient tables (c0/c1/... segment LUTs) used by the range-limited force pipeline.
- Accepts a valid/ready word stream from the host or DMA side and writes it sequentially into one LUT through the table's address/data/wren port.
- Then reads the whole table back through rden/q and checks a 32-bit additive checksum of the readback against the written stream.
- Sits between the host-load path and one LUT instance; the force pipeline must not access the table while busy is high.

Parameters:
- DEPTH, 3072, number of table words to load and verify.
- ADDR_WIDTH, 12, table address width; DEPTH must be ≤ 2^ADDR_WIDTH.
- DATA_WIDTH, 32, table word width.
- READ_LATENCY, 2, cycles from address/rden presented at the table to valid q (registered address plus registered output).

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load when idle.
- in_data  in  DATA_WIDTH  stream word.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader accepts a word this cycle.
- mem_address  out  ADDR_WIDTH  table address.
- mem_data  out  DATA_WIDTH  table write data.
- mem_wren  out  1  table write enable.
- mem_rden  out  1  table read enable.
- mem_q  in  DATA_WIDTH  table read data.
- busy  out  1  high from the cycle after an accepted start until the cycle done is asserted.
- done  out  1  one-cycle pulse at the end of verify.
- error  out  1  checksum mismatch flag; valid with done; held until the next accepted start.
- checksum  out  DATA_WIDTH  sum of written words mod 2^DATA_WIDTH; valid with done.

Behaviour:
- Reset (rst_n=0 at a clock edge), all outputs 0:
  - in_ready, mem_address, mem_data, mem_wren, mem_rden, busy, done, error, checksum.
  - FSM goes to IDLE; counters, sums and the read-valid pipe clear.
  - Reset mid-operation abandons the load; table contents are undefined until the next complete load.
- FSM states IDLE, LOAD, VERIFY, CHECK.
- IDLE:
  - start=1 → LOAD. Clear write counter, read counter, wsum, rsum and error.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1 combinationally while in LOAD and write counter < DEPTH.
  - Beat accepted when in_valid & in_ready.
  - For a beat accepted at cycle N, registered mem_address=counter, mem_data=in_data and mem_wren=1 during cycle N+1. Otherwise mem_wren=0.
  - wsum += in_data, wrapping mod 2^DATA_WIDTH. Counter increments.
  - Gaps in in_valid stall the load with no timeout.
  - On accepting beat DEPTH-1 → VERIFY; in_ready=0 from the next cycle.
- VERIFY:
  - Issue one read per cycle: registered mem_rden=1, mem_address=0..DEPTH-1 on consecutive cycles. The first read follows the last write with no overlap.
  - A READ_LATENCY-deep valid shift register tracks outstanding reads. Each returning mem_q adds into rsum, mod 2^DATA_WIDTH.
  - After the last issue, mem_rden=0. When the pipe drains (DEPTH returns counted) → CHECK.
- CHECK (one cycle):
  - done=1; checksum=wsum; error=(rsum≠wsum).
  - busy=0 in this same cycle.
  - → IDLE.
- mem_wren and mem_rden are never high in the same cycle.
- Total latency from the last accepted beat to done: DEPTH + READ_LATENCY + 2 cycles.
- DEPTH=1 must work: single write, single read.

Decomposition:
- Shared package lut_pkg holds:
  - state enum (IDLE, LOAD, VERIFY, CHECK);
  - LUT_DEPTH=3072, LUT_ADDR_WIDTH=12, LUT_DATA_WIDTH=32, LUT_READ_LATENCY=2.
- One sub-module, lut_readback_pipe: READ_LATENCY-deep valid shift register plus rsum accumulator, with clear input.
- The top holds the FSM, write path and counters.

Test Plan:
- DEPTH=8, READ_LATENCY=2, behavioural table model.
  - Start, then stream words 1..8 with in_valid held high.
  - Required: 8 writes at addresses 0..7, then 8 reads; done pulses once; checksum=36; error=0; busy=0 with done.
- Same stream with in_valid toggling 1,0,0,1…
  - Required: writes only for accepted beats, addresses contiguous, checksum=36.
- Model corrupts address 5 on readback (+1).
  - Required: done=1 with error=1; checksum=36; error holds after done until the next start.
- Words 0xFFFFFFFF×8.
  - Required: checksum=0xFFFFFFF8 (wrap); error=0.
- Assert rst_n=0 after the 4th write.
  - Required: all outputs 0 next cycle; FSM IDLE.
  - Restart completes normally.
- start pulsed during VERIFY.
  - Required: ignored; exactly one done.
- DEPTH=1, word 0xA5A5A5A5.
  - Required: one write, one read; done after READ_LATENCY+3 cycles; checksum=0xA5A5A5A5.
